lc3_decode: RTL and testbench

Decode stage of the LC3 pipeline, directly downstream of fetch. It captures the fetched instruction word together with fetch's `npc`, and registers the instruction (IR) and the execute, writeback and memory control words that the execute stage consumes. The stage holds its contents when stalled and turns into a bubble on a taken branch. Latency is one clock from capture to output.

---
 rtl/lc3_pkg.sv | 59 +++++
 rtl/lc3_decode_if.sv | 42 ++++
 rtl/lc3_decode_ctrl.sv | 72 +++++++
 rtl/lc3_decode.sv | 103 ++++++++++
 tb/tb_lc3_decode.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/lc3_pkg.sv
// ---------------------------------------------------------------------------
// lc3_pkg
// Shared LC3 pipeline types and constants.
//   opcode_e  : 4-bit instruction opcode (instr[15:12])
//   alu_op_e  : ALU operation select carried in e_control[5:4]
//   off_sel_e : address offset select carried in e_control[3:2]
//   wb_sel_e  : writeback source select (w_control)
//   cntrl_e   : per-edge pipeline register action (hold / load / flush)
//   NOP_INSTR : bubble instruction word (BR with nzp=000, never taken)
// ---------------------------------------------------------------------------
package lc3_pkg;

    typedef enum logic [3:0] {
        OP_BR   = 4'b0000,
        OP_ADD  = 4'b0001,
        OP_LD   = 4'b0010,
        OP_ST   = 4'b0011,
        OP_JSR  = 4'b0100,
        OP_AND  = 4'b0101,
        OP_LDR  = 4'b0110,
        OP_STR  = 4'b0111,
        OP_RTI  = 4'b1000,
        OP_NOT  = 4'b1001,
        OP_LDI  = 4'b1010,
        OP_STI  = 4'b1011,
        OP_JMP  = 4'b1100,
        OP_RES  = 4'b1101,
        OP_LEA  = 4'b1110,
        OP_TRAP = 4'b1111
    } opcode_e;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_AND = 2'b01,
        ALU_NOT = 2'b10
    } alu_op_e;

    typedef enum logic [1:0] {
        OFF_PC9  = 2'b00,
        OFF_OFF6 = 2'b01,
        OFF_ZERO = 2'b10
    } off_sel_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC  = 2'b10
    } wb_sel_e;

    typedef enum logic [1:0] {
        CNTRL_HOLD  = 2'b00,
        CNTRL_LOAD  = 2'b01,
        CNTRL_FLUSH = 2'b10
    } cntrl_e;

    localparam int          E_CTRL_W  = 6;
    localparam logic [15:0] NOP_INSTR = 16'h0000;

endpackage

// File: rtl/lc3_decode_if.sv
// ---------------------------------------------------------------------------
// lc3_decode_if
// Fetch -> decode -> execute signal bundle around the decode stage.
//   master : fetch/instruction-memory side; drives enable_decode, flush,
//            instr_in, npc_in and observes the registered decode outputs.
//   slave  : the decode stage itself.
// Handshake: there is no valid/ready pair. A word is taken on a rising edge
// when enable_decode=1; enable_decode=0 stalls (stage holds). flush overrides
// both and loads a bubble. dec_valid=1 marks a real instruction downstream.
// Optional macro: LC3_DECODE_ILLEGAL_TRAP_EN adds the sticky `illegal` flag.
// ---------------------------------------------------------------------------
interface lc3_decode_if #(parameter int DW = 16);
    logic          enable_decode;
    logic          flush;
    logic [DW-1:0] instr_in;
    logic [DW-1:0] npc_in;
    logic [DW-1:0] ir;
    logic [DW-1:0] npc_out;
    logic [5:0]    e_control;
    logic [1:0]    w_control;
    logic          mem_control;
    logic          dec_valid;
`ifdef LC3_DECODE_ILLEGAL_TRAP_EN
    logic          illegal;
`endif

    modport master (
        output enable_decode, flush, instr_in, npc_in,
        input  ir, npc_out, e_control, w_control, mem_control, dec_valid
`ifdef LC3_DECODE_ILLEGAL_TRAP_EN
        , input illegal
`endif
    );

    modport slave (
        input  enable_decode, flush, instr_in, npc_in,
        output ir, npc_out, e_control, w_control, mem_control, dec_valid
`ifdef LC3_DECODE_ILLEGAL_TRAP_EN
        , output illegal
`endif
    );
endinterface

// File: rtl/lc3_decode_ctrl.sv
// ---------------------------------------------------------------------------
// lc3_decode_ctrl
// Purely combinational opcode decoder.
//   opcode      in  : instr[15:12]
//   imm_sel     in  : instr[5] (immediate form of ADD/AND)
//   e_control   out : {alu_op[1:0], off_sel[1:0], base_sel, op2_sel}
//   w_control   out : writeback source (wb_sel_e)
//   mem_control out : 1 = indirect memory access (LDI/STI)
//   supported   out : 0 for JSR, RTI, reserved and TRAP (all controls 0)
// ---------------------------------------------------------------------------
module lc3_decode_ctrl
    import lc3_pkg::*;
(
    input  opcode_e    opcode,
    input  logic       imm_sel,
    output logic [5:0] e_control,
    output logic [1:0] w_control,
    output logic       mem_control,
    output logic       supported
);
    alu_op_e  alu_op;
    off_sel_e off_sel;
    wb_sel_e  wb_sel;
    logic     base_sel;
    logic     op2_sel;

    always_comb begin
        alu_op      = ALU_ADD;
        off_sel     = OFF_PC9;
        wb_sel      = WB_ALU;
        base_sel    = 1'b1;     // NPC base unless a register base is used
        op2_sel     = 1'b0;
        mem_control = 1'b0;
        supported   = 1'b1;
        case (opcode)
            OP_ADD: op2_sel = imm_sel;
            OP_AND: begin
                alu_op  = ALU_AND;
                op2_sel = imm_sel;
            end
            OP_NOT: alu_op = ALU_NOT;
            OP_BR, OP_ST: ;
            OP_LD:  wb_sel = WB_MEM;
            OP_LDI: begin
                wb_sel      = WB_MEM;
                mem_control = 1'b1;
            end
            OP_STI: mem_control = 1'b1;
            OP_LEA: wb_sel = WB_PC;
            OP_LDR: begin
                off_sel  = OFF_OFF6;
                base_sel = 1'b0;
                wb_sel   = WB_MEM;
            end
            OP_STR: begin
                off_sel  = OFF_OFF6;
                base_sel = 1'b0;
            end
            OP_JMP: begin
                off_sel  = OFF_ZERO;
                base_sel = 1'b0;
            end
            default: begin  // JSR, RTI, reserved, TRAP
                base_sel  = 1'b0;
                supported = 1'b0;
            end
        endcase
    end

    assign e_control = {alu_op, off_sel, base_sel, op2_sel};
    assign w_control = wb_sel;
endmodule

// File: rtl/lc3_decode.sv
// ---------------------------------------------------------------------------
// lc3_decode
// LC3 decode pipeline stage: registers IR, NPC and the execute/writeback/
// memory control words one clock after capture. flush > enable_decode > hold.
// Unsupported opcodes load as a bubble with ir = the fetched word.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : lc3_decode_if.slave (inputs enable_decode/flush/instr_in/
//              npc_in; outputs ir/npc_out/e_control/w_control/mem_control/
//              dec_valid, plus illegal when enabled)
// Optional macro: LC3_DECODE_ILLEGAL_TRAP_EN (sticky `illegal` flag).
// ---------------------------------------------------------------------------
module lc3_decode
    import lc3_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic         clk,
    input  logic         rst,
    lc3_decode_if.slave  bus
);
    logic [DW-1:0] ir_q;
    logic [DW-1:0] npc_q;
    logic [5:0]    e_q;
    logic [1:0]    w_q;
    logic          m_q;
    logic          valid_q;

    logic [5:0]    e_dec;
    logic [1:0]    w_dec;
    logic          m_dec;
    logic          supported;
    cntrl_e        action;

    lc3_decode_ctrl u_ctrl (
        .opcode      (opcode_e'(bus.instr_in[DW-1:DW-4])),
        .imm_sel     (bus.instr_in[5]),
        .e_control   (e_dec),
        .w_control   (w_dec),
        .mem_control (m_dec),
        .supported   (supported)
    );

    always_comb begin
        action = CNTRL_HOLD;
        if (bus.flush)
            action = CNTRL_FLUSH;
        else if (bus.enable_decode)
            action = CNTRL_LOAD;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir_q    <= '0;
            npc_q   <= '0;
            e_q     <= '0;
            w_q     <= '0;
            m_q     <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (action)
                CNTRL_FLUSH: begin
                    ir_q    <= DW'(NOP_INSTR);
                    npc_q   <= bus.npc_in;
                    e_q     <= '0;
                    w_q     <= '0;
                    m_q     <= 1'b0;
                    valid_q <= 1'b0;
                end
                CNTRL_LOAD: begin
                    // Unsupported words keep their bits in ir for debug but
                    // travel as a bubble with all controls cleared.
                    ir_q    <= bus.instr_in;
                    npc_q   <= bus.npc_in;
                    e_q     <= supported ? e_dec : '0;
                    w_q     <= supported ? w_dec : '0;
                    m_q     <= supported & m_dec;
                    valid_q <= supported;
                end
                default: ;
            endcase
        end
    end

`ifdef LC3_DECODE_ILLEGAL_TRAP_EN
    logic illegal_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            illegal_q <= 1'b0;
        else if (action == CNTRL_LOAD && !supported)
            illegal_q <= 1'b1;
    end

    assign bus.illegal = illegal_q;
`endif

    assign bus.ir          = ir_q;
    assign bus.npc_out     = npc_q;
    assign bus.e_control   = e_q;
    assign bus.w_control   = w_q;
    assign bus.mem_control = m_q;
    assign bus.dec_valid   = valid_q;
endmodule

// File: tb/tb_lc3_decode.sv
// ---------------------------------------------------------------------------
// tb_lc3_decode
// Self-checking bench for lc3_decode: directed cases followed by random
// enable/flush/instruction traffic, compared against a reference model of
// the decode rules. Honours LC3_DECODE_ILLEGAL_TRAP_EN.
// ---------------------------------------------------------------------------
module tb_lc3_decode;
    localparam int EXP_W = 42;  // {ir16, npc16, e6, w2, m1, v1}

    logic clk = 1'b0;
    logic rst = 1'b1;

    lc3_decode_if #(.DW(16)) bus ();

    lc3_decode #(.DW(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [EXP_W-1:0] exp_q[$];

    // reference model state
    logic [15:0] m_ir, m_npc;
    logic [5:0]  m_e;
    logic [1:0]  m_w;
    logic        m_m, m_v, m_ill;

    typedef struct packed {
        logic [5:0] e;
        logic [1:0] w;
        logic       m;
        logic       ok;
    } ref_t;

    function automatic ref_t decode_ref(input logic [15:0] instr);
        ref_t r;
        int op;
        int alu, off;
        logic base, op2;
        op   = int'(instr[15:12]);
        r.ok = !(op inside {4, 8, 13, 15});
        alu  = (op == 5) ? 1 : (op == 9) ? 2 : 0;
        op2  = (op inside {1, 5}) && instr[5];
        off  = (op inside {6, 7}) ? 1 : (op == 12) ? 2 : 0;
        base = !(op inside {6, 7, 12});
        r.e  = {alu[1:0], off[1:0], base, op2};
        r.w  = (op inside {2, 6, 10}) ? 2'b01 : (op == 14) ? 2'b10 : 2'b00;
        r.m  = op inside {10, 11};
        if (!r.ok) begin
            r.e = '0;
            r.w = '0;
            r.m = 1'b0;
        end
        return r;
    endfunction

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ir = '0; m_npc = '0; m_e = '0; m_w = '0; m_m = 1'b0; m_v = 1'b0; m_ill = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        logic [EXP_W-1:0] x;
        if (exp_q.size() == 0) begin
            check_val({tag, "_queue"}, 64'd0, 64'd1);
            return;
        end
        x = exp_q.pop_front();
        check_val({tag, "_ir"},  64'(bus.ir),          64'(x[41:26]));
        check_val({tag, "_npc"}, 64'(bus.npc_out),     64'(x[25:10]));
        check_val({tag, "_e"},   64'(bus.e_control),   64'(x[9:4]));
        check_val({tag, "_w"},   64'(bus.w_control),   64'(x[3:2]));
        check_val({tag, "_m"},   64'(bus.mem_control), 64'(x[1]));
        check_val({tag, "_v"},   64'(bus.dec_valid),   64'(x[0]));
`ifdef LC3_DECODE_ILLEGAL_TRAP_EN
        check_val({tag, "_ill"}, 64'(bus.illegal),     64'(m_ill));
`endif
    endtask

    // drive one cycle, update the model on the edge, check #1 later
    task automatic step(input string tag, input logic en, input logic fl,
                        input logic [15:0] instr, input logic [15:0] npc);
        ref_t r;
        @(negedge clk);
        bus.enable_decode = en;
        bus.flush         = fl;
        bus.instr_in      = instr;
        bus.npc_in        = npc;
        @(posedge clk);
        if (fl) begin
            m_ir = 16'h0000; m_npc = npc; m_e = '0; m_w = '0; m_m = 1'b0; m_v = 1'b0;
        end else if (en) begin
            r = decode_ref(instr);
            m_ir = instr; m_npc = npc; m_e = r.e; m_w = r.w; m_m = r.m; m_v = r.ok;
            if (!r.ok) m_ill = 1'b1;
        end
        exp_q.push_back({m_ir, m_npc, m_e, m_w, m_m, m_v});
        #1;
        check_outputs(tag);
    endtask

    // asynchronous reset pulse placed between clock edges
    task automatic async_reset(input string tag);
        @(negedge clk);
        bus.enable_decode = 1'b0;
        bus.flush         = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        exp_q.push_back('0);
        check_outputs(tag);
        rst = 1'b0;
    endtask

    initial begin
        bus.enable_decode = 1'b0;
        bus.flush         = 1'b0;
        bus.instr_in      = '0;
        bus.npc_in        = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back('0);
        check_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // directed cases
        step("add_imm", 1'b1, 1'b0, 16'h12A3, 16'h3001);
        check_val("add_imm_e_const", 64'(bus.e_control), 64'h03);
        step("ldr", 1'b1, 1'b0, 16'h6702, 16'h3002);
        check_val("ldr_e_const", 64'(bus.e_control), 64'h04);
        check_val("ldr_w_const", 64'(bus.w_control), 64'h1);
        step("ldi", 1'b1, 1'b0, 16'hA005, 16'h3003);
        check_val("ldi_e_const", 64'(bus.e_control), 64'h02);
        check_val("ldi_m_const", 64'(bus.mem_control), 64'h1);
        step("and_reg", 1'b1, 1'b0, 16'h5042, 16'h3004);
        check_val("and_e_const", 64'(bus.e_control), 64'h12);
        for (int i = 0; i < 3; i++)
            step("stall", 1'b0, 1'b0, 16'(i * 16'h1111 + 16'h0E21), 16'(16'h4000 + i));
        check_val("stall_ir_const", 64'(bus.ir), 64'h5042);
        step("lea", 1'b1, 1'b0, 16'hE3FF, 16'h3005);
        step("jmp", 1'b1, 1'b0, 16'hC1C0, 16'h3006);
        check_val("jmp_e_const", 64'(bus.e_control), 64'h08);
        step("flush_en", 1'b1, 1'b1, 16'h12A3, 16'h3007);
        check_val("flush_v_const", 64'(bus.dec_valid), 64'h0);
        step("not", 1'b1, 1'b0, 16'h967F, 16'h3008);
        step("stall_rst", 1'b0, 1'b0, 16'h1234, 16'h5555);
        async_reset("async_rst");
        step("post_rst", 1'b1, 1'b0, 16'h3E10, 16'h3100);

        // unsupported opcode then a legal one; flag (if present) stays set
        step("trap", 1'b1, 1'b0, 16'hF025, 16'h3101);
        check_val("trap_ir_const", 64'(bus.ir), 64'hF025);
        step("after_trap", 1'b1, 1'b0, 16'h12A3, 16'h3102);
        step("jsr", 1'b1, 1'b0, 16'h4801, 16'h3103);
        async_reset("ill_clear");

        // random traffic
        for (int i = 0; i < 400; i++) begin
            step("rand", ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
                 16'($urandom), 16'($urandom));
            if ($urandom_range(0, 99) == 0) async_reset("rand_rst");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
